// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline.
// Resolves load-use stalls, taken-branch flushes and multi-cycle MUL/DIV
// occupancy of EX, and keeps a saturating count of PC-stall cycles.
module pipeline_hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4,   // EX occupancy of MUL/DIV, 2..255
    parameter int unsigned CNT_W         = 16   // width of stall_count
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_is_muldiv,
    input  logic             ex_branch_taken,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             muldiv_start,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    // Entry cycle and the cnt==0 release cycle are not counted by cnt.
    localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 2);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             load_use;

    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Mealy control outputs and next-state selection.
    // NOTE: every output and _d signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        ex_mem_bubble  = 1'b0;
        muldiv_start   = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;

        // While reset is high the state flops already hold RUN; the inputs
        // are additionally masked so no hazard action is issued.
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (ex_valid && ex_is_muldiv) begin
                        muldiv_start   = 1'b1;
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_write_en = 1'b0;
                        ex_mem_bubble  = 1'b1;
                        cnt_d          = CNT_INIT;
                        state_d        = MD_WAIT;
                    end else if (ex_branch_taken) begin
                        // Enables stay high so the PC loads the branch target.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        // The bubble removes the load from EX, so this lasts one cycle.
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (cnt_q != 8'd0) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_write_en = 1'b0;
                        ex_mem_bubble  = 1'b1;
                        cnt_d          = cnt_q - 8'd1;
                    end else begin
                        // Release cycle: MUL/DIV result moves to EX/MEM on this edge.
                        state_d = RUN;
                    end
                end
            endcase
        end

        busy_d = (state_d == MD_WAIT);

        if (!pc_write_en && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, counters and the registered busy flag.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= 8'd0;
            busy_q        <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign muldiv_busy = busy_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// hand-written MUL/DIV / reset / saturation sequences, and random stimulus
// compared against a cycle-position reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MDC = 4;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_bubble, muldiv_start}
    localparam logic [6:0] O_RUN   = 7'b1101000;
    localparam logic [6:0] O_START = 7'b0000011;
    localparam logic [6:0] O_MDST  = 7'b0000010;
    localparam logic [6:0] O_BR    = 7'b1111100;
    localparam logic [6:0] O_LU    = 7'b0000100;

    typedef struct packed {
        logic       reset;
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_uses_rs1;
        logic       id_uses_rs2;
        logic       ex_valid;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       ex_is_muldiv;
        logic       ex_branch_taken;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_valid, ex_mem_read, ex_is_muldiv, ex_branch_taken;

    logic pc_we, ifid_we, ifid_fl, idex_we, idex_bub, exmem_bub, md_start, md_busy;
    logic [15:0] stall_cnt;
    logic pc_we4, ifid_we4, ifid_fl4, idex_we4, idex_bub4, exmem_bub4, md_start4, md_busy4;
    logic [3:0] stall_cnt4;
    logic [6:0] ctl, ctl4;

    assign ctl  = {pc_we, ifid_we, ifid_fl, idex_we, idex_bub, exmem_bub, md_start};
    assign ctl4 = {pc_we4, ifid_we4, ifid_fl4, idex_we4, idex_bub4, exmem_bub4, md_start4};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_is_muldiv(ex_is_muldiv), .ex_branch_taken(ex_branch_taken),
        .pc_write_en(pc_we), .if_id_write_en(ifid_we), .if_id_flush(ifid_fl),
        .id_ex_write_en(idex_we), .id_ex_bubble(idex_bub), .ex_mem_bubble(exmem_bub),
        .muldiv_start(md_start), .muldiv_busy(md_busy), .stall_count(stall_cnt)
    );

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_is_muldiv(ex_is_muldiv), .ex_branch_taken(ex_branch_taken),
        .pc_write_en(pc_we4), .if_id_write_en(ifid_we4), .if_id_flush(ifid_fl4),
        .id_ex_write_en(idex_we4), .id_ex_bubble(idex_bub4), .ex_mem_bubble(exmem_bub4),
        .muldiv_start(md_start4), .muldiv_busy(md_busy4), .stall_count(stall_cnt4)
    );

    int errors = 0;
    int checks = 0;
    // Reference model: position inside a MUL/DIV occupancy (-1 = none,
    // 1..MDC-1 = cycles after the first EX cycle) and the stall tally.
    int md_pos = -1;
    int model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic rst, input logic idv,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic exv,
                                 input logic [4:0] rd, input logic mr,
                                 input logic md, input logic br);
        stim_t s;
        s.reset = rst; s.id_valid = idv; s.id_rs1 = rs1; s.id_rs2 = rs2;
        s.id_uses_rs1 = u1; s.id_uses_rs2 = u2; s.ex_valid = exv; s.ex_rd = rd;
        s.ex_mem_read = mr; s.ex_is_muldiv = md; s.ex_branch_taken = br;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset = s.reset; id_valid = s.id_valid; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
        id_uses_rs1 = s.id_uses_rs1; id_uses_rs2 = s.id_uses_rs2; ex_valid = s.ex_valid;
        ex_rd = s.ex_rd; ex_mem_read = s.ex_mem_read; ex_is_muldiv = s.ex_is_muldiv;
        ex_branch_taken = s.ex_branch_taken;
    endtask

    function automatic logic [6:0] model_out(input stim_t s);
        logic lu;
        if (s.reset) return O_RUN;
        if (md_pos >= 1) return (md_pos < MDC - 1) ? O_MDST : O_RUN;
        if (s.ex_valid && s.ex_is_muldiv) return O_START;
        if (s.ex_branch_taken) return O_BR;
        lu = s.ex_valid && s.ex_mem_read && (s.ex_rd != 0) && s.id_valid &&
             ((s.id_uses_rs1 && s.id_rs1 == s.ex_rd) || (s.id_uses_rs2 && s.id_rs2 == s.ex_rd));
        return lu ? O_LU : O_RUN;
    endfunction

    // Advance the model across one rising edge taken with stimulus s.
    task automatic model_step(input stim_t s);
        logic [6:0] o;
        if (s.reset) begin
            md_pos = -1;
            model_cnt = 0;
            return;
        end
        o = model_out(s);
        if (!o[6] && model_cnt < 65535) model_cnt++;
        if (md_pos >= 1) md_pos = (md_pos == MDC - 1) ? -1 : md_pos + 1;
        else if (s.ex_valid && s.ex_is_muldiv) md_pos = 1;
    endtask

    // One full cycle compared against the model; starts and ends at posedge+1.
    task automatic run_cycle(input string name, input stim_t s);
        int c4;
        apply(s);
        #1;
        c4 = (model_cnt > 15) ? 15 : model_cnt;
        check({name, " ctl"}, 32'(ctl), 32'(model_out(s)));
        check({name, " ctl4"}, 32'(ctl4), 32'(model_out(s)));
        check({name, " busy"}, 32'(md_busy), 32'(!s.reset && md_pos >= 1));
        check({name, " cnt"}, 32'(stall_cnt), s.reset ? 32'd0 : 32'(model_cnt));
        check({name, " cnt4"}, 32'(stall_cnt4), s.reset ? 32'd0 : 32'(c4));
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        stim_t s, s_md, s_idle;
        int tally;
        logic [6:0] md_exp [8];
        logic       busy_exp [8];
        int         inc_exp [8];
        int         base;

        vecs[0] = '{s: mk(0,1,5,9,1,0,1,5,1,0,0), exp: O_LU};   // load-use on rs1
        vecs[1] = '{s: mk(0,1,5,9,1,0,0,5,1,0,0), exp: O_RUN};  // load left EX
        vecs[2] = '{s: mk(0,1,0,0,1,1,1,0,1,0,0), exp: O_RUN};  // rd = x0
        vecs[3] = '{s: mk(0,1,3,7,1,0,1,7,1,0,0), exp: O_RUN};  // rs2 matches, unused
        vecs[4] = '{s: mk(0,1,3,7,1,1,1,7,1,0,0), exp: O_LU};   // rs2 matches, used
        vecs[5] = '{s: mk(0,1,5,9,1,0,1,5,1,0,1), exp: O_BR};   // branch beats load-use
        vecs[6] = '{s: mk(0,0,5,9,1,0,1,5,1,0,0), exp: O_RUN};  // ID empty
        vecs[7] = '{s: mk(0,1,5,9,1,0,1,5,0,0,0), exp: O_RUN};  // not a load
        vecs[8] = '{s: mk(0,0,0,0,0,0,0,0,0,0,1), exp: O_BR};   // plain branch

        s_md   = mk(0,0,0,0,0,0,1,0,0,1,0);
        s_idle = mk(0,0,0,0,0,0,0,0,0,0,0);

        // Reset held with hazard-looking inputs: outputs must stay at defaults.
        apply(mk(1,1,5,9,1,0,1,5,1,1,1));
        #2;
        check("reset ctl", 32'(ctl), 32'(O_RUN));
        check("reset busy", 32'(md_busy), 32'd0);
        check("reset cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Directed single-cycle vectors.
        tally = 0;
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].s);
            #1;
            check($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].exp));
            check($sformatf("vec%0d cnt", i), 32'(stall_cnt), 32'(tally));
            @(posedge clk);
            model_step(vecs[i].s);
            if (!vecs[i].exp[6]) tally++;
            #1;
        end

        // Back-to-back MUL/DIV held in EX for 8 cycles; branch/load-use ignored.
        md_exp   = '{O_START, O_MDST, O_MDST, O_RUN, O_START, O_MDST, O_MDST, O_RUN};
        busy_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        inc_exp  = '{0, 1, 2, 3, 3, 4, 5, 6};
        base = tally;
        for (int t = 0; t < 8; t++) begin
            s = s_md;
            if (t == 0) s.ex_branch_taken = 1'b1;
            if (t == 1) s = mk(0,1,5,9,1,0,1,5,1,1,1);
            apply(s);
            #1;
            check($sformatf("md T%0d ctl", t), 32'(ctl), 32'(md_exp[t]));
            check($sformatf("md T%0d busy", t), 32'(md_busy), 32'(busy_exp[t]));
            check($sformatf("md T%0d cnt", t), 32'(stall_cnt), 32'(base + inc_exp[t]));
            @(posedge clk);
            model_step(s);
            #1;
        end
        apply(s_idle);
        #1;
        check("md after ctl", 32'(ctl), 32'(O_RUN));
        check("md after busy", 32'(md_busy), 32'd0);
        check("md after cnt", 32'(stall_cnt), 32'(base + 6));
        @(posedge clk);
        model_step(s_idle);
        #1;

        // Reset during T1 of a MUL/DIV sequence.
        apply(s_md);
        @(posedge clk);
        model_step(s_md);
        #1;
        #1;
        check("rst-md T1 ctl", 32'(ctl), 32'(O_MDST));
        check("rst-md T1 busy", 32'(md_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst-md abort ctl", 32'(ctl), 32'(O_RUN));
        check("rst-md abort busy", 32'(md_busy), 32'd0);
        check("rst-md abort cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        model_step(mk(1,0,0,0,0,0,1,0,0,1,0));
        #1;
        apply(s_idle);
        #1;
        check("rst-md after ctl", 32'(ctl), 32'(O_RUN));
        check("rst-md after busy", 32'(md_busy), 32'd0);
        @(posedge clk);
        model_step(s_idle);
        #1;

        // Saturation: 20 load-use stalls from a zero count.
        for (int i = 0; i < 20; i++) run_cycle($sformatf("sat%0d", i), vecs[0].s);
        check("sat cnt4 final", 32'(stall_cnt4), 32'd15);
        check("sat cnt16 final", 32'(stall_cnt), 32'd20);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            s.reset           = ($urandom_range(0, 49) == 0);
            s.id_valid        = ($urandom_range(0, 3) != 0);
            s.id_rs1          = 5'($urandom_range(0, 3));
            s.id_rs2          = 5'($urandom_range(0, 3));
            s.id_uses_rs1     = 1'($urandom);
            s.id_uses_rs2     = 1'($urandom);
            s.ex_valid        = ($urandom_range(0, 3) != 0);
            s.ex_rd           = 5'($urandom_range(0, 3));
            s.ex_mem_read     = 1'($urandom);
            s.ex_is_muldiv    = ($urandom_range(0, 9) == 0);
            s.ex_branch_taken = ($urandom_range(0, 5) == 0);
            run_cycle($sformatf("rnd%0d", i), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It watches the ID and EX stages and drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three cases:
- load-use stalls;
- taken-branch flushes;
- multi-cycle MUL/DIV occupancy of EX.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MULDIV_CYCLES, 4, number of cycles a MUL/DIV instruction occupies EX; legal range 2..255
- CNT_W, 16, width of stall_count

Ports:
- clk  in  1  pipeline clock, rising-edge
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_valid  in  1  EX stage (ID/EX output) holds a real instruction
- ex_rd  in  5  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_is_muldiv  in  1  EX instruction is MUL/DIV
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_write_en  out  1  PC may update
- if_id_write_en  out  1  IF/ID may load
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_write_en  out  1  ID/EX may load (0 = hold)
- id_ex_bubble  out  1  ID/EX loads all-zero (NOP, Rd=0)
- ex_mem_bubble  out  1  EX/MEM loads NOP
- muldiv_start  out  1  one-cycle start pulse to MUL/DIV unit
- muldiv_busy  out  1  registered; high while in MD_WAIT
- stall_count  out  CNT_W  saturating count of cycles with pc_write_en=0

## Operation
- FSM states: RUN, MD_WAIT. 8-bit down-counter cnt.
- Control outputs are combinational (Mealy) from state, cnt and inputs.
- Default in RUN: all write-enables = 1, all bubble/flush/start = 0.
- RUN priority, highest first:
  1. MUL/DIV: ex_valid & ex_is_muldiv.
     - Drive muldiv_start=1, pc_write_en=0, if_id_write_en=0, id_ex_write_en=0, ex_mem_bubble=1.
     - Next: cnt<=MULDIV_CYCLES-2, state<=MD_WAIT.
     - ex_branch_taken is ignored in this cycle.
  2. Branch: ex_branch_taken.
     - Drive if_id_flush=1, id_ex_bubble=1; enables stay 1 so the PC loads the target.
     - No load-use check this cycle.
  3. Load-use: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
     - Drive pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. Lasts exactly one cycle, because the bubble removes the load match.
- MD_WAIT, cnt!=0:
  - Same stall outputs as the MUL/DIV entry cycle, with muldiv_start=0.
  - cnt<=cnt-1.
  - Branch and load-use inputs are ignored.
- MD_WAIT, cnt==0: all enables = 1, no bubbles, state<=RUN. The MUL/DIV result passes to EX/MEM on this edge.
- id_ex_bubble has priority over id_ex_write_en; they are never both 1 except in the branch case, where the bubble wins.
- stall_count increments on every rising edge where pc_write_en=0 and stays at 2^CNT_W-1 once reached. It is cleared only by reset.

## Timing
- Reset (asynchronous assert, edge-synchronised release): state=RUN, cnt=0, stall_count=0, muldiv_busy=0. While reset is high, all enables = 1 and all bubble/flush/start = 0.
- Reset during MD_WAIT aborts the sequence immediately. No further stall is issued.
- Load-use costs 1 stall cycle. A taken branch costs 2 squashed slots (IF/ID and ID/EX), with no stall.
- A MUL/DIV instruction occupies EX for exactly MULDIV_CYCLES cycles and costs MULDIV_CYCLES-1 stall cycles.
- muldiv_start fires exactly once per MUL/DIV instruction, in its first EX cycle.
- muldiv_busy rises on the edge after muldiv_start and falls on the edge ending the cnt==0 cycle.
- Back-to-back MUL/DIV: the second enters EX on the release edge and starts a fresh sequence in the next cycle.

## Test plan
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, valids=1.
  - Response: in that cycle pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, stall_count 0->1. With ex_valid=0 in the next cycle, all enables=1.
- Load-use suppressed:
  - Stimulus: ex_rd=0, or id_uses_rs2=0 with only rs2 matching.
  - Response: no stall, stall_count unchanged.
- Branch:
  - Stimulus: ex_branch_taken=1 together with a load-use match.
  - Response: if_id_flush=1, id_ex_bubble=1, pc_write_en=1, stall_count unchanged.
- MUL/DIV, MULDIV_CYCLES=4:
  - Stimulus: ex_is_muldiv=1, ex_valid=1, held.
  - Response: muldiv_start pulses once at T0; stall outputs at T0..T2; release at T3; muldiv_busy=1 during T1..T3; stall_count=3.
- Reset at T1 of a MUL/DIV sequence:
  - Response: outputs return to RUN defaults at once, muldiv_busy=0, stall_count=0.
- Saturation, CNT_W=4:
  - Stimulus: 20 stall cycles.
  - Response: stall_count stops at 15.
